// File: rtl/ysyx_22050019_lsu_pkg.sv
// ysyx_22050019_lsu_pkg: funct3 codes, FSM state type and lane helpers for the LSU
package ysyx_22050019_lsu_pkg;
  localparam int LSU_XLEN = 64;
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  function automatic logic [7:0] wmask_gen(input logic [2:0] op, input logic [2:0] off);
    logic [7:0] base;
    base = op[1:0] == 2'b00 ? 8'h01 : op[1:0] == 2'b01 ? 8'h03 : op[1:0] == 2'b10 ? 8'h0F : 8'hFF;
    return base << off;
  endfunction

  function automatic logic [63:0] load_fmt(input logic [2:0] op, input logic [2:0] off,
                                           input logic [63:0] rdata);
    logic [63:0] d;
    d = rdata >> {off, 3'b000};
    case (op)
      LSU_B:   return {{56{d[7]}}, d[7:0]};
      LSU_H:   return {{48{d[15]}}, d[15:0]};
      LSU_W:   return {{32{d[31]}}, d[31:0]};
      LSU_D:   return d;
      LSU_BU:  return {56'b0, d[7:0]};
      LSU_HU:  return {48'b0, d[15:0]};
      LSU_WU:  return {32'b0, d[31:0]};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/ysyx_22050019_lsu_align.sv
// ysyx_22050019_lsu_align: store lane shift/strobe and load byte extract/extend
module ysyx_22050019_lsu_align
  import ysyx_22050019_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [2:0]  off,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output logic [63:0] wdata,
  output logic [7:0]  wmask,
  output logic [63:0] ldata
);
  assign wdata = store_data << {off, 3'b000};
  assign wmask = wmask_gen(op, off);
  assign ldata = load_fmt(op, off, rdata);
endmodule

// File: rtl/ysyx_22050019_lsu.sv
// ysyx_22050019_lsu: memory-access stage, single-outstanding dmem transaction with stall.
// Define YSYX_22050019_LSU_MISALIGN_TRAP_EN to trap misaligned H/W/D accesses via misalign_o.
module ysyx_22050019_lsu
  import ysyx_22050019_lsu_pkg::*;
#(
  parameter int XLEN  = LSU_XLEN,
  parameter int MASKW = XLEN / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      inst_i,
  input  logic             reg_we_i,
  input  logic [4:0]       reg_waddr_i,
  input  logic [XLEN-1:0]  alu_res_i,
  input  logic             mem_ren_i,
  input  logic             mem_wen_i,
  input  logic [2:0]       mem_op_i,
  input  logic [XLEN-1:0]  store_data_i,
  output logic             dmem_req_valid_o,
  input  logic             dmem_req_ready_i,
  output logic [XLEN-1:0]  dmem_req_addr_o,
  output logic             dmem_req_wen_o,
  output logic [XLEN-1:0]  dmem_req_wdata_o,
  output logic [MASKW-1:0] dmem_req_wmask_o,
  input  logic             dmem_resp_valid_i,
  input  logic [XLEN-1:0]  dmem_resp_rdata_i,
  output logic             lsu_stall_o,
  output logic             commite_o,
`ifdef YSYX_22050019_LSU_MISALIGN_TRAP_EN
  output logic             misalign_o,
`endif
  output logic [XLEN-1:0]  pc_o,
  output logic [31:0]      inst_o,
  output logic             reg_we_wbu_o,
  output logic [4:0]       reg_waddr_wbu_o,
  output logic [XLEN-1:0]  reg_wdata_wbu_o
);
  lsu_state_t state, state_n;
  logic [XLEN-1:0] ldata_q, ldata, st_wdata, wb_data;
  logic [MASKW-1:0] st_wmask;
  logic memop, mis, req, stall, commit, we;

  assign memop = valid_i & (mem_ren_i | mem_wen_i);
`ifdef YSYX_22050019_LSU_MISALIGN_TRAP_EN
  // offset bits that must be zero: none for B, [0] for H, [1:0] for W, [2:0] for D
  assign mis = memop & |(alu_res_i[2:0] & {&mem_op_i[1:0], mem_op_i[1], |mem_op_i[1:0]});
  assign misalign_o = rst_n & (state == IDLE) & mis;
`else
  assign mis = 1'b0;
`endif

  ysyx_22050019_lsu_align u_align (
    .op(mem_op_i),
    .off(alu_res_i[2:0]),
    .store_data(store_data_i),
    .rdata(dmem_resp_rdata_i),
    .wdata(st_wdata),
    .wmask(st_wmask),
    .ldata(ldata)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      ldata_q <= '0;
    end else begin
      state <= state_n;
      if (state == WAIT && dmem_resp_valid_i) ldata_q <= ldata;
    end

  always_comb begin
    state_n = state;
    req     = 1'b0;
    stall   = 1'b0;
    commit  = 1'b0;
    we      = 1'b0;
    wb_data = alu_res_i;
    case (state)
      IDLE:
        if (memop & ~mis) begin
          req     = 1'b1;
          stall   = 1'b1;
          state_n = dmem_req_ready_i ? WAIT : REQ;
        end else begin
          commit = valid_i & ~mis;
          we     = reg_we_i & ~mis;
        end
      REQ: begin
        req     = 1'b1;
        stall   = 1'b1;
        state_n = dmem_req_ready_i ? WAIT : REQ;
      end
      WAIT: begin
        stall   = 1'b1;
        state_n = dmem_resp_valid_i ? DONE : WAIT;
      end
      DONE: begin
        commit  = 1'b1;
        we      = reg_we_i & ~mem_wen_i;
        wb_data = mem_wen_i ? alu_res_i : ldata_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign dmem_req_valid_o = rst_n & req;
  assign dmem_req_addr_o  = rst_n ? {alu_res_i[XLEN-1:3], 3'b000} : '0;
  assign dmem_req_wen_o   = rst_n & mem_wen_i;
  assign dmem_req_wdata_o = rst_n ? st_wdata : '0;
  assign dmem_req_wmask_o = rst_n ? st_wmask : '0;
  assign lsu_stall_o      = rst_n & stall;
  assign commite_o        = rst_n & commit;
  assign pc_o             = rst_n ? pc_i : '0;
  assign inst_o           = rst_n ? inst_i : '0;
  assign reg_we_wbu_o     = rst_n & we;
  assign reg_waddr_wbu_o  = rst_n ? reg_waddr_i : '0;
  assign reg_wdata_wbu_o  = rst_n ? wb_data : '0;
endmodule

// File: doc/ysyx_22050019_lsu.md
Name: ysyx_22050019_lsu

Overview:
- Memory-access stage between EX_MEM and MEM_WB.
- Non-memory instructions pass through combinationally.
- Loads and stores run a single-outstanding request/response transaction on the data-memory port, and the stage asserts a stall until it completes.
- Produces the write-back tuple (reg we/addr/wdata, pc, inst, commite) consumed by MEM_WB, plus the stall that drives mem_wb_stall_i and freezes upstream stages.

Parameters:
- XLEN, 64, data/address width.
- MASKW, XLEN/8, byte-strobe width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  EX_MEM slot holds a live instruction.
- pc_i  in  XLEN  instruction pc.
- inst_i  in  32  instruction word.
- reg_we_i  in  1  rd write enable.
- reg_waddr_i  in  5  rd index.
- alu_res_i  in  XLEN  ALU result; also the effective address for memory ops.
- mem_ren_i  in  1  load.
- mem_wen_i  in  1  store.
- mem_op_i  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- store_data_i  in  XLEN  rs2 value.
- dmem_req_valid_o  out  1  request valid.
- dmem_req_ready_i  in  1  request accepted.
- dmem_req_addr_o  out  XLEN  8-byte-aligned address, {alu_res_i[63:3],3'b0}.
- dmem_req_wen_o  out  1  1 = write.
- dmem_req_wdata_o  out  XLEN  lane-shifted store data.
- dmem_req_wmask_o  out  MASKW  byte strobes.
- dmem_resp_valid_i  in  1  response (load data or write ack).
- dmem_resp_rdata_i  in  XLEN  aligned 8-byte read data.
- lsu_stall_o  out  1  stall MEM_WB and upstream.
- commite_o  out  1  instruction retires this cycle.
- pc_o  out  XLEN  pc to MEM_WB.
- inst_o  out  32  inst to MEM_WB.
- reg_we_wbu_o  out  1  write-back enable.
- reg_waddr_wbu_o  out  5  write-back index.
- reg_wdata_wbu_o  out  XLEN  write-back data.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Async reset puts it in IDLE and clears the load-data register to 0.
- While rst_n = 0, every output is forced to 0.
- memop = valid_i & (mem_ren_i | mem_wen_i).
- IDLE, memop = 0:
  - lsu_stall_o = 0; dmem_req_valid_o = 0.
  - Write-back outputs are combinational copies of the inputs; reg_wdata_wbu_o = alu_res_i; commite_o = valid_i.
  - Latency is 0 cycles.
- IDLE, memop = 1:
  - dmem_req_valid_o = 1 and lsu_stall_o = 1 in the same cycle.
  - dmem_req_ready_i = 1 → WAIT; otherwise → REQ.
- REQ: dmem_req_valid_o = 1, all request fields held stable, stall = 1. dmem_req_ready_i → WAIT.
- WAIT:
  - dmem_req_valid_o = 0, stall = 1.
  - On dmem_resp_valid_i: latch the formatted load data, → DONE.
  - A response arriving in IDLE or REQ is ignored.
- DONE:
  - stall = 0; commite_o = 1.
  - reg_wdata_wbu_o = latched data for loads, alu_res_i for stores.
  - reg_we_wbu_o = reg_we_i & ~mem_wen_i.
  - Next state is IDLE, so the same instruction is never re-issued.
- commite_o = 0 in every stalled cycle.
- Upstream holds all *_i stable while lsu_stall_o = 1.
- Best case for a memory op is 2 cycles (IDLE → WAIT → DONE with ready and response back-to-back).
- Store lane rules, with sh = alu_res_i[2:0]*8:
  - wdata = store_data_i << sh.
  - wmask = B 0x01, H 0x03, W 0x0F, D 0xFF, each shifted left by alu_res_i[2:0].
  - Truncate the mask to 8 bits.
- Load rules:
  - d = dmem_resp_rdata_i >> sh.
  - Sign-extend from bit 7/15/31 for B/H/W; zero-extend for BU/HU/WU; D unchanged.
  - Undefined mem_op codes (111) produce 0.
- Reset mid-transaction: FSM returns to IDLE, any outstanding response is dropped, no commit.
- mem_ren_i and mem_wen_i both 1: treated as a store.

Optional Feature:
- Macro: YSYX_22050019_LSU_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign_o (1 bit).
  - An H/W/D access with a misaligned address (addr[0] / addr[1:0] / addr[2:0] nonzero) issues no request; the FSM stays in IDLE.
  - misalign_o = 1 and commite_o = 0 for that cycle; reg_we_wbu_o = 0; stall = 0.
- When undefined: misaligned accesses proceed normally using the lane rules, and bytes beyond the 8-byte word are lost.

Decomposition:
- Package ysyx_22050019_lsu_pkg holds:
  - the funct3 localparams (LSU_B … LSU_WU);
  - the state enum typedef lsu_state_t;
  - the functions wmask_gen(op, off) and load_fmt(op, off, rdata).
- One natural sub-module: ysyx_22050019_lsu_align (pure combinational store shift/mask and load extract), instantiated once.

Test Plan:
- Non-memory op: valid=1, alu_res=0x1234, we=1, waddr=5 → same cycle stall=0, commite=1, wdata=0x1234, no dmem request.
- LB at 0x8000_0003, ready held 1, resp one cycle later with rdata=0x0000_0000_8000_0000 → req_addr=0x8000_0000, stall for 2 cycles, then wdata=0xFFFF_FFFF_FFFF_FF80, commite=1 for exactly 1 cycle.
- LWU at 0x8000_0004, rdata=0x8765_4321_0000_0000 → wdata=0x0000_0000_8765_4321.
- SH at 0x8000_0006, store_data=0xABCD, ready delayed 3 cycles → request fields stable across REQ; wmask=0xC0, wdata=0xABCD_0000_0000_0000; reg_we_wbu=0 at DONE.
- Reset asserted in WAIT, then a late resp_valid arrives → all outputs 0 during reset, FSM in IDLE, no commit, late response ignored.
- With the macro defined: LW at 0x8000_0002 → no dmem_req_valid, misalign_o=1, commite=0 for 1 cycle. Without the macro: the request issues with wmask-style offset 2.
